// File: rtl/retire_monitor.sv
// retire_monitor -- captures register-writeback retire events from a core's
// debug port into a trace FIFO, counts cycles/retires/drops, and halts the run
// either on a designated halt instruction or when a cycle budget runs out.
//
// Parameters
//   DEPTH       trace FIFO entries (power of two, >= 2)
//   MAX_CYCLES  cycle budget before a forced halt
//   HALT_INSTR  instruction word that ends the run (default: ebreak)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   debug_pc/instr/rd/rd_wdata/rd_we  core retire/debug interface
//   trace_valid/trace_ready         head-of-FIFO handshake
//   trace_pc/trace_rd/trace_wdata   head entry fields (zero when empty)
//   cycle_count, instr_count        cycles spent in RUN, retire events seen
//   drop_count, overflow            saturating drop counter, sticky drop flag
//   halt_cause                      0 none, 1 halt instruction, 2 cycle budget
//   done                            halted and FIFO fully drained
module retire_monitor #(
  parameter int          DEPTH      = 16,
  parameter int          MAX_CYCLES = 10000,
  parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] debug_pc,
  input  logic [31:0] debug_instr,
  input  logic [4:0]  debug_rd,
  input  logic [31:0] debug_rd_wdata,
  input  logic        debug_rd_we,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_rd,
  output logic [31:0] trace_wdata,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic [1:0]  halt_cause,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] CAUSE_HALT   = 2'd1;
  localparam logic [1:0] CAUSE_BUDGET = 2'd2;

  // Budget fires on the cycle whose increment makes cycle_count reach MAX_CYCLES.
  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);

  logic [1:0]    state, state_nxt;

  // Pointers carry one extra bit so full and empty can be told apart when
  // the index bits are equal.
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, rd_idx;

  logic [31:0]   mem_pc    [DEPTH];
  logic [4:0]    mem_rd    [DEPTH];
  logic [31:0]   mem_wdata [DEPTH];

  logic empty, full, in_run, retire, pop, push, drop;
  logic halt_hit, budget_hit;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_run     = (state == S_RUN);
  assign retire     = in_run && debug_rd_we && (debug_rd != 5'd0);
  assign pop        = !empty && trace_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // the write lands in the slot being vacated.
  assign push       = retire && (!full || pop);
  assign drop       = retire && full && !pop;
  assign halt_hit   = in_run && (debug_instr == HALT_INSTR);
  assign budget_hit = in_run && (cycle_count == LAST_CYCLE);

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (halt_hit || budget_hit) state_nxt = S_DRAIN;
      S_DRAIN: if (empty)                  state_nxt = S_DONE;
      S_DONE:                              state_nxt = S_DONE;
      default:                             state_nxt = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
      halt_cause  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (in_run) begin
        cycle_count <= cycle_count + 32'd1;
        if (retire) instr_count <= instr_count + 32'd1;
        if (halt_hit)        halt_cause <= CAUSE_HALT;
        else if (budget_hit) halt_cause <= CAUSE_BUDGET;
      end

      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; validity is carried entirely by the
  // pointers, and the outputs below are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_idx]    <= debug_pc;
      mem_rd[wr_idx]    <= debug_rd;
      mem_wdata[wr_idx] <= debug_rd_wdata;
    end
  end

  // Head is read straight from storage, so a new entry appears only after the
  // write pointer has moved past it (no same-cycle bypass).
  assign trace_valid = !empty;
  assign trace_pc    = trace_valid ? mem_pc[rd_idx]    : 32'd0;
  assign trace_rd    = trace_valid ? mem_rd[rd_idx]    : 5'd0;
  assign trace_wdata = trace_valid ? mem_wdata[rd_idx] : 32'd0;
  assign done        = (state == S_DONE);

endmodule

// File: tb/tb_retire_monitor.sv
// Self-checking bench for retire_monitor: a directed vector table, hand-written
// multi-cycle corner cases, and randomized runs against a queue-based model.
module tb_retire_monitor;

  localparam int          DEPTH = 16;
  localparam int          MAXC  = 100;
  localparam logic [31:0] HALT  = 32'h00100073;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d_pc = '0, d_instr = NOP, d_wdata = '0;
  logic [4:0]  d_rd = '0;
  logic        d_we = 1'b0, t_ready = 1'b0;
  logic        trace_valid, overflow, done;
  logic [31:0] trace_pc, trace_wdata, cycle_count, instr_count;
  logic [4:0]  trace_rd;
  logic [15:0] drop_count;
  logic [1:0]  halt_cause;

  retire_monitor #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC), .HALT_INSTR(HALT)) dut (
    .clk(clk), .rst_n(rst_n),
    .debug_pc(d_pc), .debug_instr(d_instr), .debug_rd(d_rd),
    .debug_rd_wdata(d_wdata), .debug_rd_we(d_we),
    .trace_valid(trace_valid), .trace_ready(t_ready),
    .trace_pc(trace_pc), .trace_rd(trace_rd), .trace_wdata(trace_wdata),
    .cycle_count(cycle_count), .instr_count(instr_count),
    .drop_count(drop_count), .overflow(overflow),
    .halt_cause(halt_cause), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_cyc, m_instr;
  logic [15:0] m_drop;
  logic        m_ovf, m_halted, m_done;
  logic [1:0]  m_cause;

  task automatic model_clear();
    m_q.delete();
    m_cyc = 0; m_instr = 0; m_drop = 0;
    m_ovf = 0; m_halted = 0; m_done = 0; m_cause = 0;
  endtask

  task automatic compare_model();
    check("valid", trace_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("trace_pc", trace_pc, m_q[0].pc);
      check("trace_rd", trace_rd, m_q[0].rd);
      check("trace_wdata", trace_wdata, m_q[0].wdata);
    end
    check("cycle_count", cycle_count, m_cyc);
    check("instr_count", instr_count, m_instr);
    check("drop_count", drop_count, m_drop);
    check("overflow", overflow, m_ovf);
    check("halt_cause", halt_cause, m_cause);
    check("done", done, m_done);
  endtask

  // One clock cycle: drive at the negedge, advance the model with the values
  // sampled at the posedge, compare 1 ns later, return at the next negedge.
  task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] pc,
                      input logic [31:0] wdata, input logic [31:0] instr, input logic ready);
    bit     do_pop, do_push;
    entry_t e;
    d_we = we; d_rd = rd; d_pc = pc; d_wdata = wdata; d_instr = instr; t_ready = ready;
    @(posedge clk);
    do_pop  = (m_q.size() != 0) && ready;
    do_push = 0;
    if (!m_halted) begin
      m_cyc++;
      if (we && rd != 0) begin
        m_instr++;
        if (m_q.size() < DEPTH || do_pop) do_push = 1;
        else begin
          m_ovf = 1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
      end
      if (instr == HALT) begin m_halted = 1; m_cause = 1; end
      else if (m_cyc == MAXC) begin m_halted = 1; m_cause = 2; end
    end else if (!m_done && m_q.size() == 0) begin
      m_done = 1;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      e.pc = pc; e.rd = rd; e.wdata = wdata;
      m_q.push_back(e);
    end
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 32'd0, NOP, ready);
  endtask

  // Asserts reset away from any clock edge and checks the forced values
  // before the clock can move anything.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst valid", trace_valid, 0);
    check("rst pc", trace_pc, 0);
    check("rst rd", trace_rd, 0);
    check("rst wdata", trace_wdata, 0);
    check("rst cycle", cycle_count, 0);
    check("rst instr", instr_count, 0);
    check("rst drop", drop_count, 0);
    check("rst ovf", overflow, 0);
    check("rst cause", halt_cause, 0);
    check("rst done", done, 0);
    model_clear();
    d_we = 0; d_rd = 0; d_pc = 0; d_wdata = 0; d_instr = NOP; t_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] wdata;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ok;
    vecs[0] = '{1'b1, 5'd1, 32'h100, 32'd1, 1'b1, 1'b1, 32'h100, 5'd1, 32'd1, 32'd1};
    vecs[1] = '{1'b1, 5'd2, 32'h104, 32'd2, 1'b1, 1'b1, 32'h104, 5'd2, 32'd2, 32'd2};
    vecs[2] = '{1'b1, 5'd3, 32'h108, 32'd3, 1'b1, 1'b1, 32'h108, 5'd3, 32'd3, 32'd3};
    vecs[3] = '{1'b1, 5'd4, 32'h10c, 32'd5, 1'b1, 1'b1, 32'h10c, 5'd4, 32'd5, 32'd4};
    vecs[4] = '{1'b1, 5'd0, 32'h110, 32'd9, 1'b1, 1'b0, 32'h0,   5'd0, 32'd0, 32'd4};
    vecs[5] = '{1'b0, 5'd5, 32'h114, 32'd7, 1'b1, 1'b0, 32'h0,   5'd0, 32'd0, 32'd4};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].we, vecs[i].rd, vecs[i].pc, vecs[i].wdata, NOP, vecs[i].ready);
      check($sformatf("vec%0d valid", i), trace_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d pc", i), trace_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d rd", i), trace_rd, vecs[i].exp_rd);
        check($sformatf("vec%0d wdata", i), trace_wdata, vecs[i].exp_wdata);
      end
      check($sformatf("vec%0d instr", i), instr_count, vecs[i].exp_instr);
      check($sformatf("vec%0d cycle", i), cycle_count, 32'(i + 1));
    end
    check("vec overflow", overflow, 0);

    // ---- overflow: 20 events into a 16-deep FIFO, then drain in order ----
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, 5'((i % 31) + 1), 32'h200 + 32'(i * 4), 32'(i), NOP, 1'b0);
    check("ovf instr", instr_count, 20);
    check("ovf drop", drop_count, 4);
    check("ovf flag", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf order%0d", i), trace_pc, 32'h200 + 32'(i * 4));
      idle(1, 1'b1);
    end
    check("ovf empty", trace_valid, 0);

    // ---- halt instruction at cycle 50 with 3 entries queued ----
    do_reset();
    idle(46, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 5'd10 + 5'(i), 32'h300 + 32'(i), 32'(i), NOP, 1'b0);
    step(1'b0, 5'd0, 32'h0, 32'h0, HALT, 1'b0);
    check("halt cause", halt_cause, 1);
    check("halt cycle", cycle_count, 50);
    check("halt instr", instr_count, 3);
    for (int i = 0; i < 4; i++) step(1'b1, 5'd7, 32'h400, 32'd1, NOP, 1'b0);
    check("frozen cycle", cycle_count, 50);
    check("frozen instr", instr_count, 3);
    check("drain not done", done, 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      idle(1, 1'b1);
      if (done) ok = 1;
    end
    check("halt done seen", ok, 1);
    check("halt cause held", halt_cause, 1);

    // ---- cycle budget with 2 entries queued ----
    do_reset();
    idle(97, 1'b0);
    step(1'b1, 5'd1, 32'h500, 32'd1, NOP, 1'b0);
    step(1'b1, 5'd2, 32'h504, 32'd2, NOP, 1'b0);
    idle(1, 1'b0);
    check("budget cycle", cycle_count, MAXC);
    check("budget cause", halt_cause, 2);
    check("budget not done", done, 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      idle(1, 1'b1);
      if (done) ok = 1;
    end
    check("budget done seen", ok, 1);
    check("budget cycle held", cycle_count, MAXC);

    // ---- both halt conditions in the same cycle ----
    do_reset();
    idle(99, 1'b0);
    step(1'b0, 5'd0, 32'h0, 32'h0, HALT, 1'b0);
    check("both cause", halt_cause, 1);

    // ---- reset in DRAIN with 5 entries queued ----
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 5'(i + 1), 32'h600 + 32'(i), 32'(i), NOP, 1'b0);
    step(1'b0, 5'd0, 32'h0, 32'h0, HALT, 1'b0);
    check("drain queued", trace_valid, 1);
    do_reset();
    idle(1, 1'b1);
    check("post-rst valid", trace_valid, 0);

    // ---- randomized runs against the model ----
    for (int r = 0; r < 25; r++) begin
      int bias;
      do_reset();
      bias = $urandom_range(1, 4);
      for (int c = 0; c < 220; c++) begin
        logic        we, rdy;
        logic [31:0] ins;
        we  = ($urandom_range(0, 9) < 7);
        rdy = ($urandom_range(1, 4) <= bias);
        ins = ($urandom_range(0, 79) == 0) ? HALT : NOP;
        step(we, 5'($urandom_range(0, 31)), $urandom, $urandom, ins, rdy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/retire_monitor.md
RETIRE_MONITOR -- requirements
Module: retire_monitor

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning trace FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter MAX_CYCLES, default 10000, meaning the cycle budget before a forced halt.
REQ-003 The block SHALL have parameter HALT_INSTR, default 32'h00100073 (ebreak), meaning the instruction word that ends the run.
REQ-004 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 debug_pc  input  32  PC of the instruction presented by the core.
REQ-007 debug_instr  input  32  instruction word presented by the core.
REQ-008 debug_rd  input  5  destination register of the retiring instruction.
REQ-009 debug_rd_wdata  input  32  writeback data.
REQ-010 debug_rd_we  input  1  writeback strobe.
REQ-011 trace_valid  output  1  head FIFO entry available.
REQ-012 trace_ready  input  1  consumer accepts the head entry.
REQ-013 trace_pc / trace_rd / trace_wdata  output  32/5/32  head entry fields.
REQ-014 cycle_count  output  32  cycles elapsed in RUN.
REQ-015 instr_count  output  32  retire events counted.
REQ-016 drop_count  output  16  retire events lost to a full FIFO, saturating at 16'hFFFF.
REQ-017 overflow  output  1  sticky; set on the first drop.
REQ-018 halt_cause  output  2  0 = none, 1 = HALT_INSTR, 2 = cycle budget.
REQ-019 done  output  1  run halted and FIFO fully drained.

Function
REQ-020 A retire event SHALL be defined as debug_rd_we=1 and debug_rd!=0 in a clock cycle spent in RUN.
REQ-021 The FSM SHALL have three states: RUN (the reset state), DRAIN, and DONE; DONE is terminal until reset.
REQ-022 In RUN, cycle_count SHALL increment by 1 each cycle, and instr_count SHALL increment by 1 on each retire event.
REQ-023 In RUN, each retire event SHALL push {debug_pc, debug_rd, debug_rd_wdata} into the FIFO.
REQ-024 A pushed entry SHALL become visible on the trace outputs no earlier than the next cycle (no bypass path).
REQ-025 A pop SHALL occur when trace_valid=1 and trace_ready=1.
REQ-026 Trace outputs SHALL hold stable while trace_valid=1 and trace_ready=0.
REQ-027 When the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted.
REQ-028 When the FIFO is full and no pop occurs, the push SHALL be dropped, drop_count SHALL increment (saturating), and overflow SHALL be set; instr_count SHALL still increment.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished using an extra pointer bit.
REQ-030 RUN->DRAIN with halt_cause=1 SHALL occur when debug_instr==HALT_INSTR is sampled in RUN; a retire event in that same cycle SHALL still be captured.
REQ-031 RUN->DRAIN with halt_cause=2 SHALL occur on the cycle in which cycle_count becomes MAX_CYCLES.
REQ-032 If both halt conditions occur in the same cycle, halt_cause SHALL be 1.
REQ-033 In DRAIN and DONE, the counters SHALL freeze and no pushes SHALL occur; pops SHALL continue normally.
REQ-034 DRAIN->DONE SHALL occur on the first cycle in DRAIN in which the FIFO is empty.
REQ-035 done SHALL be 1 only in DONE.
REQ-036 halt_cause SHALL hold its value once it is set.

Reset
REQ-037 rst_n=0 SHALL immediately force: state RUN, FIFO empty, trace_valid=0, trace_pc/rd/wdata=0, all counters=0, overflow=0, halt_cause=0, done=0.
REQ-038 Reset asserted mid-DRAIN or mid-DONE SHALL discard all FIFO contents, with no pops observed after reset.
REQ-039 Counting SHALL start in the first clk edge following rst_n deassertion.

Verification
REQ-040 Retire x1=1, x2=2, x3=3, x4=5 with trace_ready=1 -> four entries in order, instr_count=4, overflow=0.
REQ-041 An event with rd=0 and rd_we=1 -> no push, instr_count unchanged.
REQ-042 DEPTH=16, trace_ready=0, 20 events -> 16 entries held, drop_count=4, overflow=1, instr_count=20; then ready=1 -> 16 pops in push order.
REQ-043 HALT_INSTR presented at cycle 50 with 3 entries queued -> halt_cause=1, counters frozen, done=1 after 3 pops.
REQ-044 MAX_CYCLES=100 with no HALT_INSTR -> cycle_count=100, halt_cause=2, done asserted once the FIFO is empty.
REQ-045 rst_n pulsed low in DRAIN with 5 entries queued -> trace_valid=0 immediately and all outputs at their REQ-037 values.
